// File: rtl/pc_redirect_unit_pkg.sv
// Shared cpu front-end types: FSM state encoding, redirect kinds and instruction size.
package pc_redirect_unit_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_W        = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_JR   = 2'd1,
    RK_BR   = 2'd2,
    RK_J    = 2'd3
  } redir_kind_e;

  // Simultaneous requests collapse to the single highest-priority kind.
  function automatic redir_kind_e redirect_kind(input logic jr, input logic br, input logic j);
    if (jr)      return RK_JR;
    else if (br) return RK_BR;
    else if (j)  return RK_J;
    else         return RK_NONE;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Execute-side redirect requests in, fetch PC and status out.
interface pc_redirect_unit_if;

  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] pcOut;
  logic        fetch_valid;
  logic        flush;
  logic        misalign_err;

  modport master (
    output stall, jump, jump_index, jr, jr_target, branch_taken, branch_offset,
    input  pcOut, fetch_valid, flush, misalign_err
  );

  modport slave (
    input  stall, jump, jump_index, jr, jr_target, branch_taken, branch_offset,
    output pcOut, fetch_valid, flush, misalign_err
  );

endinterface

// File: rtl/pc_redirect_unit_redirect_target_calc.sv
// Combinational redirect target for j / jr / taken branch relative to the current fetch PC.
module redirect_target_calc
  import pc_redirect_unit_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  redir_kind_e     kind_i,
  input  logic [25:0]     jump_index_i,
  input  logic [31:0]     jr_target_i,
  input  logic [15:0]     branch_offset_i,
  output logic [PC_W-1:0] target_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_disp;

  assign pc_plus4 = pc_i + PC_W'(INSTR_BYTES);
  assign br_disp  = {{16{branch_offset_i[15]}}, branch_offset_i} << 2;

  always_comb begin
    target_o   = pc_i;
    misalign_o = 1'b0;
    unique case (kind_i)
      RK_JR: begin
        target_o   = {jr_target_i[31:2], 2'b00};
        misalign_o = |jr_target_i[1:0];
      end
      RK_BR:   target_o = pc_plus4 + br_disp;
      RK_J:    target_o = {pc_plus4[31:28], jump_index_i, 2'b00};
      RK_NONE: target_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-bundle PC generator: sequential stepping, stall hold, redirects with a fixed flush window.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned     CORES        = 4,
  parameter logic [31:0]     RESET_PC     = 32'd0,
  parameter int unsigned     FLUSH_CYCLES = 1
)(
  input  logic                clk,
  input  logic                reset,
  pc_redirect_unit_if.slave   bus
);

  localparam int unsigned      CNT_W      = 3;
  localparam int unsigned      STEP_BYTES = INSTR_BYTES * CORES;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;

  redir_kind_e      kind_c;
  logic [PC_W-1:0]  target_c;
  logic             misalign_c;

  assign kind_c = redirect_kind(bus.jr, bus.branch_taken, bus.jump);

  redirect_target_calc u_target_calc (
    .pc_i            (pc_q),
    .kind_i          (kind_c),
    .jump_index_i    (bus.jump_index),
    .jr_target_i     (bus.jr_target),
    .branch_offset_i (bus.branch_offset),
    .target_o        (target_c),
    .misalign_o      (misalign_c)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b1;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  // Next state: a redirect opens the window, the counter closes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (kind_c != RK_NONE) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
  end

  // Next register values for the outputs; FLUSH ignores all requests and stall.
  always_comb begin
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    misalign_d    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (kind_c != RK_NONE) begin
          pc_d          = target_c;
          fetch_valid_d = 1'b0;
          flush_d       = 1'b1;
          misalign_d    = misalign_c;
        end else begin
          fetch_valid_d = 1'b1;
          flush_d       = 1'b0;
          if (!bus.stall) pc_d = pc_q + PC_W'(STEP_BYTES);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          fetch_valid_d = 1'b1;
          flush_d       = 1'b0;
        end
      end
    endcase
  end

  assign bus.pcOut        = pc_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_err = misalign_q;

endmodule
